// File: rtl/parser_input_arbiter.sv
// Packet-granular round-robin arbiter in front of the sequence parser.
// Holds a grant for a whole packet, truncates oversize packets and drains the rest.
module parser_input_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 12,
  localparam int GW = $clog2(NUM_SRC),
  localparam int CW = $clog2(MAX_BEATS + 1)
) (
  input  logic                    clk,
  input  logic                    reset_b,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]      src_val,
  input  logic [NUM_SRC-1:0]      src_last,
  output logic [NUM_SRC-1:0]      src_ready,
  output logic [DATA_W-1:0]       dataIn,
  output logic                    dataIn_val,
  output logic                    dataIn_last,
  input  logic                    dataIn_ready,
  output logic [GW-1:0]           grant_id,
  output logic                    busy,
  output logic                    oversize_err,
  output logic [15:0]             fwd_pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    FORWARD,
    DRAIN
  } state_t;

  state_t          state;
  logic [GW-1:0]   rrPtr;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   nextPtr;
  logic [CW-1:0]   beatCnt;
  logic            anyReq;
  logic            atMax;
  logic            gVal;
  logic            gLast;
  logic [DATA_W-1:0] gData;

  // Scan from the far end so the lowest offset from rrPtr wins.
  always_comb begin
    pick   = rrPtr;
    anyReq = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      int j;
      j = int'(rrPtr) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (src_val[j]) begin
        pick   = GW'(j);
        anyReq = 1'b1;
      end
    end
  end

  assign gVal    = src_val[grant_id];
  assign gLast   = src_last[grant_id];
  assign gData   = src_data[int'(grant_id)*DATA_W +: DATA_W];
  assign atMax   = (beatCnt == CW'(MAX_BEATS - 1));
  assign nextPtr = (grant_id == GW'(NUM_SRC - 1)) ? '0
                 : grant_id + GW'(1);
  assign busy    = (state != IDLE);

  always_comb begin
    src_ready   = '0;
    dataIn      = '0;
    dataIn_val  = 1'b0;
    dataIn_last = 1'b0;
    case (state)
      FORWARD: begin
        src_ready[grant_id] = dataIn_ready;
        dataIn      = gData;
        dataIn_val  = gVal;
        dataIn_last = gLast | atMax;
      end
      DRAIN: begin
        src_ready[grant_id] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state        <= IDLE;
      rrPtr        <= '0;
      grant_id     <= '0;
      beatCnt      <= '0;
      oversize_err <= 1'b0;
      fwd_pkt_cnt  <= '0;
    end else begin
      oversize_err <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            grant_id <= pick;
            beatCnt  <= '0;
            state    <= FORWARD;
          end
        end
        FORWARD: begin
          if (gVal && dataIn_ready) begin
            if (gLast) begin
              beatCnt     <= '0;
              fwd_pkt_cnt <= fwd_pkt_cnt + 16'd1;
              rrPtr       <= nextPtr;
              state       <= IDLE;
            end else if (atMax) begin
              beatCnt      <= '0;
              fwd_pkt_cnt  <= fwd_pkt_cnt + 16'd1;
              oversize_err <= 1'b1;
              state        <= DRAIN;
            end else begin
              beatCnt <= beatCnt + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (gVal && gLast) begin
            rrPtr <= nextPtr;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parser_input_arbiter.sv
// Directed bench for parser_input_arbiter.
// Sources are fed from per-source beat tables; accepted parser beats are logged.
module tb_parser_input_arbiter;
  localparam int NS = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset_b;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]   src_val;
  logic [NS-1:0]   src_last;
  logic [NS-1:0]   src_ready;
  logic [DW-1:0]   dataIn;
  logic            dataIn_val;
  logic            dataIn_last;
  logic            dataIn_ready;
  logic [1:0]      grant_id;
  logic            busy;
  logic            oversize_err;
  logic [15:0]     fwd_pkt_cnt;

  parser_input_arbiter #(
    .NUM_SRC(NS), .DATA_W(DW), .MAX_BEATS(12)
  ) dut (
    .clk(clk), .reset_b(reset_b),
    .src_data(src_data), .src_val(src_val),
    .src_last(src_last), .src_ready(src_ready),
    .dataIn(dataIn), .dataIn_val(dataIn_val),
    .dataIn_last(dataIn_last),
    .dataIn_ready(dataIn_ready),
    .grant_id(grant_id), .busy(busy),
    .oversize_err(oversize_err),
    .fwd_pkt_cnt(fwd_pkt_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [32:0] srcMem[NS][64];
  int head[NS];
  int tail[NS];
  logic [NS-1:0] hold;
  logic [32:0] outMem[128];
  int outCyc[128];
  int outN = 0;
  int cyc = 0;
  int base;
  logic [31:0] t1Exp[4];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input logic [31:0] d, input logic l);
    srcMem[s][tail[s]] = {l, d};
    tail[s]++;
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      if (!hold[i] && head[i] < tail[i]) begin
        src_val[i]  = 1'b1;
        src_last[i] = srcMem[i][head[i]][32];
        src_data[i*DW +: DW] = srcMem[i][head[i]][31:0];
      end else begin
        src_val[i]  = 1'b0;
        src_last[i] = 1'b0;
        src_data[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic step();
    #1;
    if (dataIn_val && dataIn_ready) begin
      outMem[outN] = {dataIn_last, dataIn};
      outCyc[outN] = cyc;
      outN++;
    end
    for (int i = 0; i < NS; i++)
      if (src_val[i] && src_ready[i]) head[i]++;
    @(posedge clk);
    cyc++;
    #1;
    drive();
    #1;
  endtask

  task automatic settle(input int budget);
    int n;
    bit pend;
    n = 0;
    pend = 1'b1;
    while (pend && n < budget) begin
      pend = busy;
      for (int i = 0; i < NS; i++)
        if (head[i] < tail[i]) pend = 1'b1;
      if (pend) begin
        step();
        n++;
      end
    end
    chk("settle_pending", {31'd0, pend}, 32'd0);
  endtask

  initial begin
    reset_b = 1'b0;
    dataIn_ready = 1'b0;
    hold = '0;
    for (int i = 0; i < NS; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    t1Exp[0] = 32'h000C0003;
    t1Exp[1] = 32'h00000005;
    t1Exp[2] = 32'h000000A1;
    t1Exp[3] = 32'h000000B2;
    drive();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_val", dataIn_val, 0);
    chk("rst_last", dataIn_last, 0);
    chk("rst_data", dataIn, 0);
    chk("rst_ready", src_ready, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_oversize", oversize_err, 0);
    chk("rst_fwd", fwd_pkt_cnt, 0);
    @(negedge clk);
    reset_b = 1'b1;

    // Single 4-beat packet from source 1
    dataIn_ready = 1'b1;
    push(1, 32'h000C0003, 1'b0);
    push(1, 32'h00000005, 1'b0);
    push(1, 32'h000000A1, 1'b0);
    push(1, 32'h000000B2, 1'b1);
    drive();
    #1;
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_ready", src_ready, 0);
    step();
    chk("t1_grant", grant_id, 1);
    chk("t1_busy", busy, 1);
    chk("t1_srcready", src_ready, 4'b0010);
    chk("t1_first", dataIn, 32'h000C0003);
    chk("t1_first_last", dataIn_last, 0);
    repeat (4) step();
    chk("t1_outn", outN, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_beat", outMem[k][31:0], t1Exp[k]);
      chk("t1_beat_last", outMem[k][32], (k == 3));
    end
    chk("t1_done_busy", busy, 0);
    chk("t1_fwd", fwd_pkt_cnt, 1);
    push(0, 32'hD0, 1'b1);
    push(2, 32'hD2, 1'b1);
    drive();
    #1;
    step();
    chk("t1_rr_next", grant_id, 2);
    settle(20);
    chk("t1_rr_a", outMem[4], {1'b1, 32'hD2});
    chk("t1_rr_b", outMem[5], {1'b1, 32'hD0});
    chk("t1_fwd3", fwd_pkt_cnt, 3);

    // Backpressure and source stall on source 2
    base = outN;
    push(0, 32'hF0, 1'b1);
    push(3, 32'hF3, 1'b1);
    push(2, 32'hE0, 1'b0);
    push(2, 32'hE1, 1'b0);
    push(2, 32'hE2, 1'b0);
    push(2, 32'hE3, 1'b1);
    drive();
    #1;
    step();
    chk("t3_grant", grant_id, 2);
    for (int k = 0; k < 4; k++) begin
      dataIn_ready = (k == 0 || k == 3);
      #1;
      chk("t3_others", src_ready & 4'b1011, 0);
      chk("t3_ready2", src_ready[2], dataIn_ready);
      step();
    end
    dataIn_ready = 1'b1;
    hold[2] = 1'b1;
    drive();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("t3_stall_val", dataIn_val, 0);
      chk("t3_stall_grant", grant_id, 2);
      chk("t3_stall_others", src_ready & 4'b1011, 0);
      step();
    end
    hold[2] = 1'b0;
    drive();
    #1;
    chk("t3_resume", dataIn, 32'hE2);
    settle(30);
    chk("t3_outn", outN - base, 6);
    for (int k = 0; k < 4; k++)
      chk("t3_beat", outMem[base+k], {k == 3, 32'hE0 + k});
    chk("t3_next_a", outMem[base+4], {1'b1, 32'hF3});
    chk("t3_next_b", outMem[base+5], {1'b1, 32'hF0});
    chk("t3_fwd", fwd_pkt_cnt, 6);

    // 15-beat packet on source 0 is cut at beat 12
    base = outN;
    for (int k = 1; k <= 15; k++)
      push(0, 32'h100 + k, k == 15);
    drive();
    #1;
    step();
    chk("t4_grant", grant_id, 0);
    repeat (11) step();
    chk("t4_b12_data", dataIn, 32'h10C);
    chk("t4_b12_last", dataIn_last, 1);
    chk("t4_pre_err", oversize_err, 0);
    push(1, 32'h1F1, 1'b1);
    step();
    chk("t4_err", oversize_err, 1);
    chk("t4_drain_val", dataIn_val, 0);
    chk("t4_drain_busy", busy, 1);
    chk("t4_drain_ready", src_ready, 4'b0001);
    chk("t4_fwd", fwd_pkt_cnt, 7);
    step();
    chk("t4_err_pulse", oversize_err, 0);
    chk("t4_drain_val2", dataIn_val, 0);
    step();
    step();
    chk("t4_idle", busy, 0);
    step();
    chk("t4_next_grant", grant_id, 1);
    settle(20);
    chk("t4_outn", outN - base, 13);
    chk("t4_b11", outMem[base+10], {1'b0, 32'h10B});
    chk("t4_b12", outMem[base+11], {1'b1, 32'h10C});
    chk("t4_src1", outMem[base+12], {1'b1, 32'h1F1});
    chk("t4_fwd2", fwd_pkt_cnt, 8);

    // Natural last exactly on beat 12
    base = outN;
    for (int k = 1; k <= 12; k++)
      push(3, 32'h300 + k, k == 12);
    drive();
    #1;
    step();
    chk("t5_grant", grant_id, 3);
    repeat (11) step();
    chk("t5_b12_last", dataIn_last, 1);
    step();
    chk("t5_err", oversize_err, 0);
    chk("t5_idle", busy, 0);
    chk("t5_fwd", fwd_pkt_cnt, 9);
    step();
    chk("t5_err2", oversize_err, 0);
    chk("t5_b12", outMem[base+11], {1'b1, 32'h30C});

    // Reset mid-packet on beat 3
    for (int k = 1; k <= 5; k++)
      push(1, 32'h500 + k, k == 5);
    drive();
    #1;
    step();
    chk("t6_grant", grant_id, 1);
    repeat (2) step();
    chk("t6_beat3", dataIn, 32'h503);
    reset_b = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_val", dataIn_val, 0);
    chk("t6_ready", src_ready, 0);
    chk("t6_fwd", fwd_pkt_cnt, 0);
    for (int i = 0; i < NS; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    drive();
    @(negedge clk);
    reset_b = 1'b1;

    // All sources requesting 3-beat packets
    base = outN;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NS; s++)
        for (int b = 0; b < 3; b++)
          push(s, s*256 + p*16 + b, b == 2);
    drive();
    #1;
    settle(100);
    chk("rr_outn", outN - base, 24);
    for (int k = 0; k < 24; k++) begin
      int p, s, b;
      p = k / 12;
      s = (k / 3) % 4;
      b = k % 3;
      chk("rr_beat", outMem[base+k], {b == 2, 32'(s*256 + p*16 + b)});
      if (k > 0)
        chk("rr_gap", outCyc[base+k] - outCyc[base+k-1],
            (b == 0) ? 2 : 1);
    end
    chk("rr_fwd", fwd_pkt_cnt, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parser_input_arbiter.md
Name: parser_input_arbiter

Overview:
Packet-granular round-robin arbiter that shares the single parser receive interface between NUM_SRC upstream packet sources. It grants one source per packet and holds the grant until that source's last beat is accepted. It guards the parser against oversize packets by forcing last at MAX_BEATS and draining the remainder. It sits directly in front of the sequence parser and drives its dataIn/dataIn_val/dataIn_last/dataIn_ready handshake.

Parameters:
NUM_SRC, 4, number of requesting sources (2..16)
DATA_W, 32, beat width in bits
MAX_BEATS, 12, max beats per packet incl. header and sequence words (>=2)

Ports:
clk  input  1  clock
reset_b  input  1  asynchronous reset, active low
src_data  input  NUM_SRC*DATA_W  source beats, source i at [i*DATA_W +: DATA_W]
src_val  input  NUM_SRC  per-source beat valid
src_last  input  NUM_SRC  per-source last beat of packet
src_ready  output  NUM_SRC  per-source beat accepted when val&ready
dataIn  output  DATA_W  beat to parser
dataIn_val  output  1  beat valid to parser
dataIn_last  output  1  last beat to parser
dataIn_ready  input  1  parser ready
grant_id  output  clog2(NUM_SRC)  currently granted source, meaningful when busy=1
busy  output  1  high in FORWARD or DRAIN
oversize_err  output  1  one-cycle pulse when a packet is truncated
fwd_pkt_cnt  output  16  packets delivered to parser, wraps 0xFFFF->0

Behaviour:
- Reset (async, reset_b=0): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, oversize_err=0, fwd_pkt_cnt=0. All src_ready=0, dataIn_val=0, dataIn_last=0, dataIn=0 while in reset. A reset mid-packet aborts it with no flush; the remainder is upstream's problem.
- States: IDLE, FORWARD, DRAIN.
- IDLE:
  - all src_ready=0, dataIn_val=0.
  - If any src_val is set, pick the first i with src_val[i]=1, scanning rr_ptr, rr_ptr+1, … mod NUM_SRC.
  - Register grant_id=i and beat_cnt=0, go to FORWARD.
  - One-cycle arbitration bubble per packet.
- FORWARD, g=grant_id:
  - Combinational pass-through: dataIn=src_data[g], dataIn_val=src_val[g], src_ready[g]=dataIn_ready, other src_ready=0.
  - dataIn_last = src_last[g] | (beat_cnt==MAX_BEATS-1).
  - Accepted beat = dataIn_val & dataIn_ready. On each accepted beat, beat_cnt+1.
  - Accepted with src_last[g]=1: fwd_pkt_cnt+1, rr_ptr=(g+1) mod NUM_SRC, go to IDLE. This holds even when beat_cnt==MAX_BEATS-1; that case is not an error.
  - Accepted with beat_cnt==MAX_BEATS-1 and src_last[g]=0: forced last delivered, fwd_pkt_cnt+1, oversize_err=1 next cycle for exactly one cycle, go to DRAIN.
  - src_val[g] dropping mid-packet: grant held, dataIn_val=0, no timeout.
- DRAIN:
  - dataIn_val=0, src_ready[g]=1, other src_ready=0; beats are discarded.
  - Accepted beat with src_last[g]=1: rr_ptr=(g+1) mod NUM_SRC, go to IDLE.
- Requests from non-granted sources never affect the current packet. Only accepted src_last (or force) releases the grant.
- Fairness: with all sources continuously requesting, the grant order is 0,1,2,…,NUM_SRC-1,0…
- beat_cnt width is clog2(MAX_BEATS+1); beat_cnt never exceeds MAX_BEATS-1.
- No combinational path from dataIn_ready to dataIn_val.

Test Plan:
- Single source 1 sends a 4-beat packet (0x000C0003, 0x00000005, 0xA1, 0xB2 last), dataIn_ready=1:
  - required: grant_id=1 one cycle after src_val[1];
  - required: 4 beats out in order, dataIn_last only on 0xB2;
  - required: fwd_pkt_cnt=1, rr_ptr=2.
- All 4 sources continuously requesting 3-beat packets: packet order on dataIn is 0,1,2,3,0; no beats interleave between packets; one idle cycle between packets.
- Source 2 granted, dataIn_ready toggles 1,0,0,1 and src_val[2] deasserts for 2 cycles mid-packet:
  - required: no beat duplicated or lost;
  - required: grant held and src_ready[0,1,3]=0 throughout.
- MAX_BEATS=12, source 0 sends a 15-beat packet:
  - required: beat 12 is output with dataIn_last=1, then oversize_err is a one-cycle pulse;
  - required: beats 13–15 are absorbed with dataIn_val=0;
  - required: next grant goes to source 1 if requesting.
- Packet with src_last exactly on beat 12: normal completion, oversize_err stays 0, state goes straight to IDLE.
- Assert reset_b=0 mid-packet on beat 3:
  - required: immediately busy=0, dataIn_val=0, all src_ready=0, fwd_pkt_cnt=0;
  - required: after release, arbitration restarts at source 0.
